bp_update_sched: RTL and testbench
==================================

// Module: bp_update_sched
// PURPOSE
//   Scheduler for the branch-predictor 2-bit counter table (single-port, 1-cycle read latency).
//   Shares the table port between IF-stage lookups and ROB-commit counter updates.
//   Queues commit outcomes in a small FIFO and serialises each update as a read-modify-write.
//   Sequences a full-table clear after reset and on request. Sits between IF, ROB and the table.
// PARAMETERS
//   IDX_W       7   table index width; index = pc[IDX_W+1:2], 2**IDX_W entries
//   Q_DEPTH     4   update FIFO depth (power of 2, >=2)
//   STARVE_MAX  4   consecutive lookup-won cycles before a pending update read is forced
//   CLR_INIT    2'b01  counter value written by the clear sweep (weakly not-taken)
// PORTS
//   clk          in   1      clock, all state on rising edge
//   rst          in   1      asynchronous, active-low reset
//   rdy          in   1      global enable; low = freeze all state, no table access
//   clear_req    in   1      1-cycle pulse: discard queued updates, start clear sweep
//   commit_valid in   1      ROB commits a conditional branch this cycle
//   commit_pc    in   32     pc of committed branch
//   commit_taken in   1      real outcome
//   commit_ready out  1      FIFO not full; push only when valid && ready
//   lookup_req   in   1      IF requests prediction
//   lookup_pc    in   32     IF pc
//   lookup_gnt   out  1      lookup owns table port this cycle
//   pred_valid   out  1      registered; 1 cycle after lookup_gnt
//   pred_taken   out  1      tbl_rdata[1], valid when pred_valid
//   clear_busy   out  1      sweep in progress
//   tbl_addr     out  IDX_W  table address
//   tbl_we       out  1      table write enable
//   tbl_wdata    out  2      write data
//   tbl_rdata    in   2      read data for address of previous cycle
// BEHAVIOUR
//   Reset (rst=0, async): FIFO empty, starve cnt 0, pred_valid 0, tbl_we 0, tbl_addr 0;
//     state CLEAR with sweep ptr 0 (clear_busy 1, commit_ready 0).
//   States: CLEAR, IDLE, UPD_RD, UPD_WR.
//   CLEAR: each rdy cycle tbl_we=1, addr=ptr, wdata=CLR_INIT, ptr++; after ptr=2**IDX_W-1 -> IDLE.
//     Exactly 2**IDX_W write cycles. lookup_gnt=0, commit_ready=0 throughout.
//   Port priority per cycle: CLEAR write > UPD_WR > lookup > UPD_RD.
//   IDLE: FIFO non-empty -> UPD_RD. UPD_RD: if lookup_req and starve<STARVE_MAX, lookup wins,
//     starve++, stay; else issue read of head idx, pop head, starve=0, -> UPD_WR.
//   UPD_WR: tbl_we=1, addr=latched idx, wdata=sat(tbl_rdata): taken ? min(v+1,3) : max(v-1,0);
//     -> UPD_RD if FIFO non-empty else IDLE. Lookup not granted in UPD_WR cycle.
//   Serialised RD/WR: back-to-back updates to same index need no forwarding.
//   Lookup: gnt -> addr=lookup_pc[IDX_W+1:2]; next cycle pred_valid=1, pred_taken=rdata[1].
//   FIFO: entries {idx,taken}; commit_ready=!full (registered count); push/pop same cycle allowed
//     when not full; push ignored if ready=0 (ROB must hold).
//   clear_req (rdy=1): highest priority; flush FIFO, abort pending UPD_WR (no write), ptr=0,
//     -> CLEAR next cycle. clear_req during CLEAR restarts sweep at 0.
//   rdy=0: no state change, tbl_we=0, lookup_gnt=0, pred_valid holds; inputs ignored.
//   Reset mid-sweep or mid-update: abandon, restart as above.
// TESTING
//   Boot: release rst, rdy=1 -> 128 writes of 2'b01 to addr 0..127, clear_busy falls cycle 129.
//   Saturation: 4 taken commits pc=0x10 -> idx 4 writes 2,3,3,3; 4 not-taken -> 2,1,0,0;
//     lookup pc=0x10 after -> pred_taken=0.
//   Starvation: lookup_req held high, 1 update queued -> 4 lookup grants, then UPD_RD, then UPD_WR.
//   Backpressure: lookup_req high, 5 commits -> commit_ready=0 after 4 pushed; 5th held, accepted
//     after first pop.
//   clear_req while UPD_WR pending with 3 queued -> no update write, FIFO empty, 128-cycle sweep.
//   rdy low 3 cycles mid-UPD_RD -> no tbl_we, state/FIFO unchanged; resumes identically.

Source files
------------

// File: rtl/bp_update_sched_if.sv
// Bus between bp_update_sched and its neighbours (IF lookup, ROB commit,
// 2-bit counter table). The slave modport is the scheduler. The master
// modport is everything around it: the IF/ROB side and the table's read data.
//   rdy, clear_req          global enable, clear-sweep request
//   commit_*                ROB commit push (valid/ready handshake)
//   lookup_*, pred_*        IF prediction request / registered result
//   clear_busy              sweep in progress
//   tbl_*                   single-port table, 1-cycle read latency
interface bp_update_sched_if #(
    parameter int IDX_W = 7
);
    logic             rdy;
    logic             clear_req;
    logic             commit_valid;
    logic [31:0]      commit_pc;
    logic             commit_taken;
    logic             commit_ready;
    logic             lookup_req;
    logic [31:0]      lookup_pc;
    logic             lookup_gnt;
    logic             pred_valid;
    logic             pred_taken;
    logic             clear_busy;
    logic [IDX_W-1:0] tbl_addr;
    logic             tbl_we;
    logic [1:0]       tbl_wdata;
    logic [1:0]       tbl_rdata;

    modport slave (
        input  rdy, clear_req, commit_valid, commit_pc, commit_taken,
               lookup_req, lookup_pc, tbl_rdata,
        output commit_ready, lookup_gnt, pred_valid, pred_taken,
               clear_busy, tbl_addr, tbl_we, tbl_wdata
    );

    modport master (
        output rdy, clear_req, commit_valid, commit_pc, commit_taken,
               lookup_req, lookup_pc, tbl_rdata,
        input  commit_ready, lookup_gnt, pred_valid, pred_taken,
               clear_busy, tbl_addr, tbl_we, tbl_wdata
    );
endinterface

// File: rtl/bp_update_sched.sv
// Branch-predictor counter-table scheduler. Shares one single-port table
// (1-cycle read latency) between IF lookups and ROB-commit counter updates.
// Commit outcomes are queued and applied as serialised read-modify-writes.
// A full-table clear sweep runs after reset and on clear_req.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   bus      bp_update_sched_if.slave (commit push, lookup/pred, table port)
// Table-port outputs are combinational from state and this cycle's
// requests. That lets a lookup granted in cycle t see its data in t+1.
module bp_update_sched #(
    parameter int         IDX_W      = 7,
    parameter int         Q_DEPTH    = 4,
    parameter int         STARVE_MAX = 4,
    parameter logic [1:0] CLR_INIT   = 2'b01
) (
    input logic              clk,
    input logic              rst,
    bp_update_sched_if.slave bus
);
    localparam int QA_W = $clog2(Q_DEPTH);
    localparam int ST_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {CLEAR, IDLE, UPD_RD, UPD_WR} state_t;
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    upd_t              q [Q_DEPTH];
    logic [QA_W-1:0]   wr_ptr, rd_ptr;
    logic [QA_W:0]     count;
    logic [ST_W-1:0]   starve;
    upd_t              lat;
    logic              pred_valid_r;

    logic              active, starved, gnt, push, pop, commit_ready;
    logic [IDX_W-1:0]  lk_idx;
    upd_t              head;

    function automatic logic [1:0] sat2(input logic [1:0] v, input logic up);
        if (up) return (v == 2'b11) ? v : v + 2'b01;
        else    return (v == 2'b00) ? v : v - 2'b01;
    endfunction

    // Any cycle that may touch state: out of reset, enabled, and not being
    // pre-empted by a clear request (which suppresses all table traffic).
    assign active  = rst && bus.rdy && !bus.clear_req;
    assign starved = (starve >= ST_W'(STARVE_MAX));
    assign lk_idx  = bus.lookup_pc[IDX_W+1:2];
    assign head    = q[rd_ptr];

    assign gnt  = active && bus.lookup_req &&
                  (state == IDLE || (state == UPD_RD && !starved));
    assign pop  = active && (state == UPD_RD) && !gnt;
    // Ready is also dropped while frozen or clearing so the ROB never sees
    // a handshake whose push is then discarded.
    assign commit_ready = active && (state != CLEAR) &&
                          (count != (QA_W+1)'(Q_DEPTH));
    assign push = bus.commit_valid && commit_ready;

    assign bus.commit_ready = commit_ready;
    assign bus.lookup_gnt   = gnt;
    assign bus.pred_valid   = pred_valid_r;
    assign bus.pred_taken   = bus.tbl_rdata[1];
    assign bus.clear_busy   = (state == CLEAR);

    always_comb begin
        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = CLR_INIT;
        if (state == CLEAR) begin
            bus.tbl_we   = active;
            bus.tbl_addr = ptr;
        end else if (state == UPD_WR) begin
            bus.tbl_we    = active;
            bus.tbl_addr  = lat.idx;
            bus.tbl_wdata = sat2(bus.tbl_rdata, lat.taken);
        end else if (gnt) begin
            bus.tbl_addr = lk_idx;
        end else if (state == UPD_RD) begin
            bus.tbl_addr = head.idx;
        end
    end

    // FIFO payload needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) q[wr_ptr] <= '{idx: bus.commit_pc[IDX_W+1:2], taken: bus.commit_taken};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= CLEAR;
            ptr          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            starve       <= '0;
            lat          <= '0;
            pred_valid_r <= 1'b0;
        end else if (bus.rdy) begin
            pred_valid_r <= gnt;
            if (bus.clear_req) begin
                state  <= CLEAR;
                ptr    <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                starve <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + QA_W'(1);
                if (pop) begin
                    rd_ptr <= rd_ptr + QA_W'(1);
                    lat    <= head;
                end
                count <= count + (QA_W+1)'(push) - (QA_W+1)'(pop);
                case (state)
                    CLEAR: begin
                        ptr <= ptr + IDX_W'(1);
                        if (ptr == {IDX_W{1'b1}}) state <= IDLE;
                    end
                    IDLE:   if (count != '0) state <= UPD_RD;
                    UPD_RD: begin
                        if (gnt) starve <= starve + ST_W'(1);
                        else begin
                            starve <= '0;
                            state  <= UPD_WR;
                        end
                    end
                    UPD_WR: state <= (count != '0) ? UPD_RD : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.commit_pc[31:IDX_W+2], bus.commit_pc[1:0],
                              bus.lookup_pc[31:IDX_W+2], bus.lookup_pc[1:0]};
endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: boot sweep, table-driven
// update/lookup vectors, then starvation, backpressure, clear-abort and
// rdy-freeze sequences. The 2-bit table is modelled as a 1-cycle-latency RAM.
module tb_bp_update_sched;
    logic clk, rst;
    bp_update_sched_if #(.IDX_W(7)) bus ();

    bp_update_sched #(.IDX_W(7), .Q_DEPTH(4), .STARVE_MAX(4), .CLR_INIT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] mem [128];
    always @(posedge clk) begin
        if (bus.tbl_we) mem[bus.tbl_addr] <= bus.tbl_wdata;
        bus.tbl_rdata <= mem[bus.tbl_addr];
    end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nxt(); @(posedge clk); #1; endtask
    task automatic smp(); @(negedge clk); endtask

    // Count sweep writes from the current cycle until clear_busy drops.
    task automatic sweep(input string name);
        int nwr = 0, bad = 0, gbad = 0, fall = 0;
        for (int c = 1; c <= 300; c++) begin
            smp();
            if (!bus.clear_busy) begin fall = c; break; end
            if (bus.tbl_we) begin
                if (bus.tbl_addr !== nwr[6:0] || bus.tbl_wdata !== 2'b01) bad++;
                nwr++;
            end else bad++;
            if (bus.lookup_gnt) gbad++;
            nxt();
        end
        chk({name, "_writes"}, nwr, 128);
        chk({name, "_busy_fall_cycle"}, fall, 129);
        chk({name, "_bad_cycles"}, bad, 0);
        chk({name, "_gnt_during_clear"}, gbad, 0);
    endtask

    task automatic wait_write(input string name, output logic [6:0] a, output logic [1:0] d);
        bit got = 0;
        a = '0; d = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            smp();
            if (bus.tbl_we) begin got = 1; a = bus.tbl_addr; d = bus.tbl_wdata; end
            nxt();
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL %s: no table write within 20 cycles", name);
        end
    endtask

    typedef struct {
        bit          is_lookup;
        logic [31:0] pc;
        logic        taken;
        logic [6:0]  exp_addr;
        logic [1:0]  exp_val;   // write data for commits, pred_taken for lookups
    } vec_t;
    vec_t vt [16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [6:0]  a;
        logic [1:0]  d;
        logic [31:0] pcs [5];
        int e, nw, rlow, e4c, fwr, nbad, rdc;
        logic [6:0] wa [8];
        logic [1:0] wd [8];

        vt[0]  = '{0, 32'h10, 1, 7'd4, 2'd2};
        vt[1]  = '{0, 32'h10, 1, 7'd4, 2'd3};
        vt[2]  = '{0, 32'h10, 1, 7'd4, 2'd3};
        vt[3]  = '{0, 32'h10, 1, 7'd4, 2'd3};
        vt[4]  = '{0, 32'h10, 0, 7'd4, 2'd2};
        vt[5]  = '{0, 32'h10, 0, 7'd4, 2'd1};
        vt[6]  = '{0, 32'h10, 0, 7'd4, 2'd0};
        vt[7]  = '{0, 32'h10, 0, 7'd4, 2'd0};
        vt[8]  = '{0, 32'h20, 1, 7'd8, 2'd2};
        vt[9]  = '{0, 32'h20, 1, 7'd8, 2'd3};
        vt[10] = '{1, 32'h10, 0, 7'd4, 2'd0};
        vt[11] = '{1, 32'h20, 0, 7'd8, 2'd1};
        vt[12] = '{1, 32'h23, 0, 7'd8, 2'd1};
        vt[13] = '{1, 32'h210, 0, 7'd4, 2'd0};
        vt[14] = '{1, 32'h220, 0, 7'd8, 2'd1};
        vt[15] = '{1, 32'h0, 0, 7'd0, 2'd0};

        for (int i = 0; i < 128; i++) mem[i] = 2'b11;
        rst = 1'b0;
        bus.rdy = 1'b1; bus.clear_req = 1'b0;
        bus.commit_valid = 1'b0; bus.commit_pc = '0; bus.commit_taken = 1'b0;
        bus.lookup_req = 1'b1; bus.lookup_pc = '0;

        // ---- reset state and boot sweep ----
        nxt(); nxt();
        smp();
        chk("rst_clear_busy", bus.clear_busy, 1);
        chk("rst_commit_ready", bus.commit_ready, 0);
        chk("rst_pred_valid", bus.pred_valid, 0);
        chk("rst_tbl_we", bus.tbl_we, 0);
        chk("rst_tbl_addr", bus.tbl_addr, 0);
        chk("rst_lookup_gnt", bus.lookup_gnt, 0);
        nxt();
        rst = 1'b1;
        sweep("boot");
        nbad = 0;
        for (int i = 0; i < 128; i++) if (mem[i] !== 2'b01) nbad++;
        chk("boot_mem_not_init", nbad, 0);
        nxt();
        bus.lookup_req = 1'b0;

        // ---- table-driven update / lookup vectors ----
        for (int i = 0; i < 16; i++) begin
            if (!vt[i].is_lookup) begin
                bus.commit_valid = 1'b1; bus.commit_pc = vt[i].pc; bus.commit_taken = vt[i].taken;
                smp();
                chk($sformatf("vec%0d_ready", i), bus.commit_ready, 1);
                nxt();
                bus.commit_valid = 1'b0;
                wait_write($sformatf("vec%0d_wr", i), a, d);
                chk($sformatf("vec%0d_addr", i), a, vt[i].exp_addr);
                chk($sformatf("vec%0d_wdata", i), d, vt[i].exp_val);
            end else begin
                bus.lookup_req = 1'b1; bus.lookup_pc = vt[i].pc;
                smp();
                chk($sformatf("vec%0d_gnt", i), bus.lookup_gnt, 1);
                chk($sformatf("vec%0d_addr", i), bus.tbl_addr, vt[i].exp_addr);
                nxt();
                bus.lookup_req = 1'b0;
                smp();
                chk($sformatf("vec%0d_pred_valid", i), bus.pred_valid, 1);
                chk($sformatf("vec%0d_pred_taken", i), bus.pred_taken, vt[i].exp_val);
                nxt();
            end
        end

        // ---- starvation: lookup held high, one update queued ----
        bus.lookup_req = 1'b1; bus.lookup_pc = 32'h0;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h30; bus.commit_taken = 1'b1;
        smp();
        chk("starve_push_ready", bus.commit_ready, 1);
        nxt();
        bus.commit_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            smp();
            chk($sformatf("starve_gnt_k%0d", k), bus.lookup_gnt, (k <= 5 || k == 8) ? 1 : 0);
            if (k == 6) begin
                chk("starve_rd_addr", bus.tbl_addr, 12);
                chk("starve_rd_we", bus.tbl_we, 0);
            end
            if (k == 7) begin
                chk("starve_wr_we", bus.tbl_we, 1);
                chk("starve_wr_addr", bus.tbl_addr, 12);
                chk("starve_wr_data", bus.tbl_wdata, 2);
            end
            nxt();
        end

        // ---- backpressure: 5 commits against a full FIFO ----
        pcs = '{32'h40, 32'h44, 32'h48, 32'h4c, 32'h50};
        e = 0; nw = 0; rlow = -1; e4c = -1; fwr = -1;
        for (int c = 0; c < 40; c++) begin
            bus.lookup_req   = (e < 5);
            bus.commit_valid = (e < 5);
            bus.commit_pc    = pcs[e < 5 ? e : 4];
            bus.commit_taken = 1'b1;
            smp();
            if (bus.commit_valid && bus.commit_ready) begin
                if (e == 4) e4c = c;
                e++;
            end else if (e < 5 && !bus.commit_ready && rlow < 0) rlow = e;
            if (bus.tbl_we) begin
                if (fwr < 0) fwr = c;
                wa[nw] = bus.tbl_addr; wd[nw] = bus.tbl_wdata; nw++;
            end
            nxt();
            if (nw == 5) break;
        end
        bus.commit_valid = 1'b0; bus.lookup_req = 1'b0;
        chk("bp_pushed_before_full", rlow, 4);
        chk("bp_5th_accept_cycle", e4c, fwr);
        chk("bp_write_count", nw, 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_wr%0d_addr", i), wa[i], 16 + i);
            chk($sformatf("bp_wr%0d_data", i), wd[i], 2);
        end

        // ---- clear_req while UPD_WR pending, 3 still queued ----
        e = 0; rdc = -1;
        bus.lookup_req = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.commit_valid = (e < 4);
            bus.commit_pc    = 32'h60 + 32'(e * 4);
            smp();
            if (bus.commit_valid && bus.commit_ready) e++;
            if (!bus.lookup_gnt && !bus.tbl_we && !bus.clear_busy) begin rdc = c; break; end
            nxt();
        end
        chk("clr_reached_read", rdc, 6);
        nxt();
        bus.commit_valid = 1'b0;
        bus.clear_req = 1'b1;
        smp();
        chk("clr_abort_we", bus.tbl_we, 0);
        chk("clr_gnt", bus.lookup_gnt, 0);
        nxt();
        bus.clear_req = 1'b0;
        sweep("clr");
        chk("clr_mem8_reinit", mem[8], 1);
        nxt();
        bus.lookup_req = 1'b0;
        nw = 0;
        for (int c = 0; c < 10; c++) begin
            smp();
            if (bus.tbl_we) nw++;
            nxt();
        end
        chk("clr_fifo_flushed", nw, 0);

        // ---- rdy low 3 cycles mid UPD_RD ----
        bus.lookup_req = 1'b1;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h78; bus.commit_taken = 1'b0;
        smp();
        chk("rdy_push_ready", bus.commit_ready, 1);
        nxt();
        bus.commit_valid = 1'b0;
        smp(); nxt();      // IDLE
        smp(); nxt();      // UPD_RD, first lookup win
        bus.rdy = 1'b0;
        bus.commit_valid = 1'b1; bus.commit_pc = 32'h7c; bus.commit_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk($sformatf("rdy0_we_%0d", k), bus.tbl_we, 0);
            chk($sformatf("rdy0_gnt_%0d", k), bus.lookup_gnt, 0);
            chk($sformatf("rdy0_predv_%0d", k), bus.pred_valid, 1);
            nxt();
        end
        bus.rdy = 1'b1; bus.commit_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            smp();
            chk($sformatf("rdy1_gnt_k%0d", k), bus.lookup_gnt, (k <= 3) ? 1 : 0);
            chk($sformatf("rdy1_we_k%0d", k), bus.tbl_we, (k == 5) ? 1 : 0);
            if (k >= 4) chk($sformatf("rdy1_addr_k%0d", k), bus.tbl_addr, 30);
            if (k == 5) chk("rdy1_wdata", bus.tbl_wdata, 0);
            nxt();
        end
        bus.lookup_req = 1'b0;
        nw = 0;
        for (int c = 0; c < 6; c++) begin
            smp();
            if (bus.tbl_we) nw++;
            nxt();
        end
        chk("rdy0_push_ignored", nw, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
